// File: rtl/audio_pkg.sv
// audio_pkg
//   Shared definitions for the flash audio playback path: sequencer state
//   encoding, address/sample widths, the default song end address and the
//   wrapping word-address step used when moving through the song.
package audio_pkg;

   localparam int FLASH_ADDR_W = 23;
   localparam int SAMPLE_W     = 16;
   localparam int WORD_W       = 2 * SAMPLE_W;

   localparam logic [FLASH_ADDR_W-1:0] DEFAULT_LAST_ADDR = 23'h7FFFF;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_DATA,
      WAIT_T0,
      OUT0,
      WAIT_T1,
      OUT1,
      ADVANCE
   } seq_state_t;

   // One word step through the song, wrapping at both ends.
   function automatic logic [FLASH_ADDR_W-1:0] next_addr(
      input logic [FLASH_ADDR_W-1:0] addr,
      input logic                    forward,
      input logic [FLASH_ADDR_W-1:0] last_addr
   );
      logic [FLASH_ADDR_W-1:0] result;
      if (forward)
         result = (addr == last_addr) ? '0 : addr + 1'b1;
      else
         result = (addr == '0) ? last_addr : addr - 1'b1;
      return result;
   endfunction

endpackage

// File: rtl/edge_to_pulse.sv
// edge_to_pulse
//   Turns a slow level (already synchronous to clk) into a registered
//   one-cycle pulse on each of its rising edges.
//   Ports:
//     clk    in  system clock
//     reset  in  synchronous active-high reset
//     level  in  slow strobe / square wave
//     pulse  out one-cycle pulse, the cycle after the rise is sampled
module edge_to_pulse (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic pulse
);

   logic level_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         // Track the live level during reset so a line that is already high
         // when reset releases does not produce a phantom edge.
         level_reg <= level;
         pulse     <= 1'b0;
      end else begin
         level_reg <= level;
         pulse     <= level & ~level_reg;
      end
   end

endmodule

// File: rtl/flash_audio_sequencer.sv
// flash_audio_sequencer
//   Reads 32-bit words from flash over an Avalon-MM read master and plays
//   the two 16-bit samples of each word, one per sample-clock rising edge.
//   Forward play emits [15:0] then [31:16]; backward play emits the halves
//   in the opposite order and walks the address downwards.
//   Ports:
//     clk, reset              system clock, synchronous active-high reset
//     start_reading           1 = play, 0 = pause (honoured at word boundaries)
//     direction               1 = forward, 0 = backward (sampled per word)
//     restart                 one-cycle request to jump to the song start
//     sample_clk              slow sample-rate square wave, synchronous to clk
//     flash_*                 Avalon-MM read master (word addressed)
//     audio_data/audio_valid  current sample and its one-cycle update strobe
module flash_audio_sequencer
   import audio_pkg::*;
#(
   parameter logic [FLASH_ADDR_W-1:0] LAST_ADDR = DEFAULT_LAST_ADDR
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start_reading,
   input  logic                    direction,
   input  logic                    restart,
   input  logic                    sample_clk,
   input  logic                    flash_waitrequest,
   input  logic                    flash_readdatavalid,
   input  logic [WORD_W-1:0]       flash_readdata,
   output logic                    flash_read,
   output logic [FLASH_ADDR_W-1:0] flash_address,
   output logic [3:0]              flash_byteenable,
   output logic [SAMPLE_W-1:0]     audio_data,
   output logic                    audio_valid
);

   seq_state_t        state;
   logic              tick;
   logic              restart_pending;
   logic              restart_now;
   logic              dir_q;
   logic [WORD_W-1:0] word_reg;

   assign flash_byteenable = 4'hF;

   // A restart arriving in the very cycle it would be consumed is applied
   // immediately rather than waiting for the next word boundary.
   assign restart_now = restart_pending | restart;

   edge_to_pulse u_tick (
      .clk   (clk),
      .reset (reset),
      .level (sample_clk),
      .pulse (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         flash_read      <= 1'b0;
         flash_address   <= '0;
         audio_data      <= '0;
         audio_valid     <= 1'b0;
         restart_pending <= 1'b0;
         dir_q           <= 1'b1;
         word_reg        <= '0;
      end else begin
         audio_valid <= 1'b0;
         if (restart)
            restart_pending <= 1'b1;

         case (state)
            IDLE: begin
               // While paused a restart reloads the start point using the
               // live direction, since no word has latched one yet.
               if (restart_now) begin
                  flash_address   <= direction ? '0 : LAST_ADDR;
                  restart_pending <= 1'b0;
               end
               if (start_reading) begin
                  flash_read <= 1'b1;
                  state      <= REQ;
               end
            end

            REQ: begin
               if (!flash_waitrequest) begin
                  flash_read <= 1'b0;
                  state      <= WAIT_DATA;
               end
            end

            WAIT_DATA: begin
               if (flash_readdatavalid) begin
                  word_reg <= flash_readdata;
                  dir_q    <= direction;
                  state    <= WAIT_T0;
               end
            end

            WAIT_T0: begin
               if (tick) begin
                  audio_data  <= dir_q ? word_reg[SAMPLE_W-1:0] : word_reg[WORD_W-1:SAMPLE_W];
                  audio_valid <= 1'b1;
                  state       <= OUT0;
               end
            end

            OUT0: state <= WAIT_T1;

            WAIT_T1: begin
               if (tick) begin
                  audio_data  <= dir_q ? word_reg[WORD_W-1:SAMPLE_W] : word_reg[SAMPLE_W-1:0];
                  audio_valid <= 1'b1;
                  state       <= OUT1;
               end
            end

            OUT1: state <= ADVANCE;

            ADVANCE: begin
               if (restart_now) begin
                  flash_address   <= dir_q ? '0 : LAST_ADDR;
                  restart_pending <= 1'b0;
               end else begin
                  flash_address <= next_addr(flash_address, dir_q, LAST_ADDR);
               end
               if (start_reading) begin
                  flash_read <= 1'b1;
                  state      <= REQ;
               end else begin
                  state <= IDLE;
               end
            end

            default: begin
               flash_read <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flash_audio_sequencer.sv
// tb_flash_audio_sequencer
//   Randomised self-checking bench. A behavioural flash slave answers the
//   read master with random waitrequest and latency; a transaction-level
//   model predicts the sample stream and the address sequence from the
//   play rules (word order by direction, wrapping steps, sticky restart,
//   pause at word boundaries). One per-cycle process compares the DUT
//   against the model, and the first few words are pinned to literals.
module tb_flash_audio_sequencer;
   import audio_pkg::*;

   localparam logic [22:0] LAST = 23'h7FFFF;
   localparam int SPERIOD = 40;

   logic        clk = 1'b0;
   logic        reset, start_reading, direction, restart, sample_clk;
   logic        flash_waitrequest, flash_readdatavalid;
   logic [31:0] flash_readdata;
   logic        flash_read;
   logic [22:0] flash_address;
   logic [3:0]  flash_byteenable;
   logic [15:0] audio_data;
   logic        audio_valid;

   always #10 clk = ~clk;

   flash_audio_sequencer #(.LAST_ADDR(LAST)) dut (
      .clk                 (clk),
      .reset               (reset),
      .start_reading       (start_reading),
      .direction           (direction),
      .restart             (restart),
      .sample_clk          (sample_clk),
      .flash_waitrequest   (flash_waitrequest),
      .flash_readdatavalid (flash_readdatavalid),
      .flash_readdata      (flash_readdata),
      .flash_read          (flash_read),
      .flash_address       (flash_address),
      .flash_byteenable    (flash_byteenable),
      .audio_data          (audio_data),
      .audio_valid         (audio_valid)
   );

   int total = 0;
   int bad   = 0;

   // model state
   logic [15:0] exp_q[$];
   logic [15:0] last_sample = 16'h0;
   logic [22:0] exp_addr    = 23'h0;
   logic        pending     = 1'b0;
   logic        word_dir    = 1'b1;
   logic [22:0] addr_log[$];
   logic [15:0] samp_log[$];
   int          words = 0, samples = 0;
   bit          idle_phase = 0;
   int          idle_cnt = 0, idle_len = 0;
   bit          idle_rst = 0;
   bit          do_drop = 0, do_restart = 0;

   // stimulus / slave state
   int  cyc = 0, rise_cyc = -100;
   int  lat_cnt = 0, hold_cnt = 0;
   bit  held = 0;
   bit  check_en = 0, drive_en = 0;
   logic        prev_read = 1'b0;
   logic [22:0] prev_addr = 23'h0;
   logic        script_dir[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // First sample of a word: the word in flight must finish regardless of
   // pause/restart requested now.
   task automatic first_sample_event();
      if (words >= 6) begin
         if ($urandom_range(0, 4) == 0) do_drop = 1;
         if ($urandom_range(0, 3) == 0) begin
            do_restart = 1;
            pending    = 1'b1;
         end
      end
   endtask

   // Second sample of a word: the word boundary decides the next address
   // and whether play pauses.
   task automatic word_done_event();
      if (pending) begin
         exp_addr = word_dir ? 23'h0 : LAST;
         pending  = 1'b0;
      end else if (word_dir) begin
         exp_addr = (exp_addr == LAST) ? 23'h0 : exp_addr + 23'd1;
      end else begin
         exp_addr = (exp_addr == 23'h0) ? LAST : exp_addr - 23'd1;
      end
      if (!start_reading) begin
         idle_phase = 1;
         idle_cnt   = 0;
         idle_len   = $urandom_range(8, 30);
         idle_rst   = ($urandom_range(0, 1) == 1);
      end
   endtask

   task automatic compare_outputs();
      check("byteenable", 32'(flash_byteenable), 32'h0000_000F);
      check("read_in_pause", 32'(flash_read & idle_phase), 32'h0);
      if (flash_read) check("read_addr", 32'(flash_address), 32'(exp_addr));
      if (prev_read) begin
         // still requesting while stalled, dropped once accepted
         check("read_handshake", 32'(flash_read), 32'(flash_waitrequest));
         if (flash_read) check("addr_stable", 32'(flash_address), 32'(prev_addr));
      end
      if (audio_valid) begin
         check("valid_timing", 32'(cyc - rise_cyc), 32'd2);
         if (exp_q.size() == 0) begin
            check("spurious_valid", 32'(audio_valid), 32'h0);
         end else begin
            last_sample = exp_q.pop_front();
            check("sample", 32'(audio_data), 32'(last_sample));
            samp_log.push_back(audio_data);
            samples++;
            if (samples % 2 == 1) first_sample_event();
            else                  word_done_event();
         end
      end else begin
         check("hold", 32'(audio_data), 32'(last_sample));
      end
      prev_read = flash_read;
      prev_addr = flash_address;
   endtask

   task automatic drive_inputs();
      logic        new_sclk;
      logic [31:0] word;
      restart  = 1'b0;
      new_sclk = ((cyc % SPERIOD) >= (SPERIOD / 2));
      if (new_sclk && !sample_clk) rise_cyc = cyc;
      sample_clk = new_sclk;

      if (do_drop)    begin start_reading = 1'b0; do_drop = 0;    end
      if (do_restart) begin restart = 1'b1;       do_restart = 0; end

      if (idle_phase) begin
         idle_cnt++;
         if (idle_cnt == 2) direction = 1'($urandom_range(0, 1));
         if (idle_cnt == 4 && idle_rst) begin
            restart  = 1'b1;
            exp_addr = direction ? 23'h0 : LAST;
         end
         if (idle_cnt == idle_len) begin
            start_reading = 1'b1;
            idle_phase    = 0;
         end
      end else if (words >= 4 && $urandom_range(0, 15) == 0) begin
         direction = ~direction;
      end

      // flash slave
      flash_readdatavalid = 1'b0;
      if (lat_cnt > 0) begin
         lat_cnt--;
         if (lat_cnt == 0) begin
            if (words < 4) direction = script_dir[words];
            word = (words == 0) ? 32'hAAAA_5555 :
                   (words == 2) ? 32'h1234_5678 : $urandom;
            flash_readdata      = word;
            flash_readdatavalid = 1'b1;
            word_dir = direction;
            exp_q.push_back(direction ? word[15:0]  : word[31:16]);
            exp_q.push_back(direction ? word[31:16] : word[15:0]);
            words++;
         end
      end
      if (hold_cnt > 0) begin
         flash_waitrequest = 1'b1;
         hold_cnt--;
      end else if (words == 1 && !held && flash_read) begin
         held = 1;
         hold_cnt = 4;
         flash_waitrequest = 1'b1;
      end else begin
         flash_waitrequest = ($urandom_range(0, 2) == 0);
      end
      if (flash_read && !flash_waitrequest) begin
         addr_log.push_back(flash_address);
         lat_cnt = $urandom_range(1, 4);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      if (check_en) compare_outputs();
      if (drive_en) drive_inputs();
   endtask

   initial begin
      bit found;
      reset = 1'b1; start_reading = 1'b0; direction = 1'b1; restart = 1'b0;
      sample_clk = 1'b0; flash_waitrequest = 1'b0; flash_readdatavalid = 1'b0;
      flash_readdata = 32'h0;
      repeat (3) @(negedge clk);
      check("reset_read",  32'(flash_read),    32'h0);
      check("reset_addr",  32'(flash_address), 32'h0);
      check("reset_data",  32'(audio_data),    32'h0);
      check("reset_valid", 32'(audio_valid),   32'h0);

      reset = 1'b0;
      start_reading = 1'b1;
      check_en = 1;
      drive_en = 1;
      repeat (6000) step();

      // literal pins for the scripted opening words
      check("enough_samples", 32'(samples >= 40), 32'h1);
      if (addr_log.size() >= 5 && samp_log.size() >= 6) begin
         check("lit_addr0", 32'(addr_log[0]), 32'h0);
         check("lit_addr1", 32'(addr_log[1]), 32'h1);
         check("lit_addr2", 32'(addr_log[2]), 32'h0);
         check("lit_addr3", 32'(addr_log[3]), 32'h7FFFF);
         check("lit_addr4", 32'(addr_log[4]), 32'h0);
         check("lit_samp0", 32'(samp_log[0]), 32'h5555);
         check("lit_samp1", 32'(samp_log[1]), 32'hAAAA);
         check("lit_samp4", 32'(samp_log[4]), 32'h1234);
         check("lit_samp5", 32'(samp_log[5]), 32'h5678);
      end else begin
         check("log_length", 32'(addr_log.size()), 32'd5);
      end

      // reset while a read is outstanding, then a late readdatavalid
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         step();
         if (flash_read) found = 1;
      end
      check("found_read", 32'(found), 32'h1);
      check_en = 0;
      drive_en = 0;
      flash_waitrequest = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_read", 32'(flash_read),    32'h0);
      check("rst_mid_addr", 32'(flash_address), 32'h0);
      reset = 1'b0;
      start_reading = 1'b0;
      flash_readdatavalid = 1'b1;
      flash_readdata = 32'hFFFF_0000;
      @(negedge clk);
      flash_readdatavalid = 1'b0;
      for (int i = 0; i < 2 * SPERIOD; i++) begin
         sample_clk = ((i % SPERIOD) >= (SPERIOD / 2));
         @(negedge clk);
         check("late_rdv_valid", 32'(audio_valid), 32'h0);
         check("late_rdv_read",  32'(flash_read),  32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/flash_audio_sequencer.md
# flash_audio_sequencer

Sequences 32-bit word reads from the on-board flash and streams the two 16-bit audio samples per word to the audio output, one sample per sample-clock rising edge. It is driven by the keyboard FSM's `start_reading` (play/pause) and `direction` (forward/backward) outputs, plus a restart request. It sits between the keyboard FSM, the flash Avalon-MM read master port and the audio DAC interface.

## Interface
- `LAST_ADDR`, default 23'h7FFFF: final word address of the song; the address wraps at this value.
- `clk`  in  1  system clock (50 MHz); all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_reading`  in  1  1 = play, 0 = pause; from the keyboard FSM.
- `direction`  in  1  1 = forward, 0 = backward; from the keyboard FSM.
- `restart`  in  1  one-cycle request to jump to the song start.
- `sample_clk`  in  1  slow square wave (e.g. 22 kHz), already synchronised to `clk`.
- `flash_waitrequest`  in  1  Avalon waitrequest.
- `flash_readdatavalid`  in  1  Avalon readdatavalid.
- `flash_readdata`  in  32  Avalon read data.
- `flash_read`  out  1  Avalon read strobe.
- `flash_address`  out  23  word address.
- `flash_byteenable`  out  4  constant 4'hF.
- `audio_data`  out  16  current sample; holds its value between updates.
- `audio_valid`  out  1  one-cycle pulse when `audio_data` updates.

## Operation
- States:
  - IDLE
  - REQ
  - WAIT_DATA
  - WAIT_T0
  - OUT0
  - WAIT_T1
  - OUT1
  - ADVANCE
- `tick` is the one-cycle rising-edge pulse of `sample_clk`.
- IDLE: if `start_reading` = 1, go to REQ; otherwise stay.
- REQ: assert `flash_read`. Hold it until a cycle with `flash_waitrequest` = 0, then go to WAIT_DATA.
- WAIT_DATA: when `flash_readdatavalid` = 1, latch `flash_readdata` into the word register and latch `direction` into `dir_q`. Go to WAIT_T0.
- WAIT_T0 → OUT0 on `tick`.
  - OUT0 drives the first half: [15:0] if `dir_q` = 1, else [31:16].
  - OUT0 pulses `audio_valid` and goes to WAIT_T1.
- WAIT_T1 → OUT1 on `tick`.
  - OUT1 drives the other half and pulses `audio_valid`.
  - OUT1 goes to ADVANCE.
- ADVANCE, address update:
  - If restart is pending: address = 0 when `dir_q` = 1, else LAST_ADDR. Clear the pending flag.
  - Otherwise, forward: address+1, wrapping LAST_ADDR→0.
  - Otherwise, backward: address−1, wrapping 0→LAST_ADDR.
- ADVANCE, next state: REQ if `start_reading` = 1, else IDLE.
- Pause takes effect only at a word boundary; the current word always finishes both samples.
- Direction is sampled once per word, in WAIT_DATA. A direction change mid-word applies from the next word.
- `restart` sets a sticky pending flag in any state. It is consumed in ADVANCE.
  - In IDLE with the flag set, the address is reloaded (using the live `direction`) and the flag is cleared before leaving to REQ.
- `restart` and ADVANCE in the same cycle: the restart wins and is applied immediately.

## Timing
- Reset values: state IDLE, `flash_read` 0, `flash_address` 0, `audio_data` 0, `audio_valid` 0, restart flag 0, `dir_q` 1.
- `flash_byteenable` is always 4'hF.
- `tick` is asserted the cycle after `sample_clk` is seen rising (1-cycle detect latency).
- `audio_valid` and the new `audio_data` appear in the cycle after the state sees `tick` (registered outputs).
- Ticks arriving in REQ or WAIT_DATA are not queued. The sequencer waits for the next tick, so the flash round trip must finish within one sample period.
- `flash_address` changes only in ADVANCE or IDLE. It is stable while `flash_read` = 1.
- `reset` mid-read: drop `flash_read` on the next edge and ignore any late `readdatavalid`.

## Structure
- Shared package `audio_pkg`:
  - state enum `seq_state_t`
  - `FLASH_ADDR_W` = 23
  - `SAMPLE_W` = 16
  - default `LAST_ADDR`
- Sub-module `edge_to_pulse` (clk, reset, level in, one-cycle pulse out) produces `tick`. It is shared with other slow-strobe users.

## Test plan
- Reset, then `start_reading`=1, `direction`=1, word 0 = 32'hAAAA_5555 → `flash_read` at address 0; after two ticks `audio_data` = 16'h5555 then 16'hAAAA, each with one `audio_valid` pulse; next request at address 1.
- `direction`=0, address 0, word 32'h1234_5678 → outputs 16'h1234 then 16'h5678; next address = LAST_ADDR (wrap).
- Forward at address LAST_ADDR → next `flash_address` = 0.
- `flash_waitrequest` held high 5 cycles → `flash_read` and `flash_address` stay stable for all 5; exactly one word captured.
- `start_reading` drops between the two ticks of a word → second sample still output, then IDLE with no further `flash_read`; raising it again resumes at the next address.
- `restart` pulse mid-word at address 0x100, forward → word finishes, next request at address 0; `restart` during IDLE with backward → next request at LAST_ADDR.
